// File: rtl/clock_pkg.sv
// clock_pkg: time limits, field width, mode encoding and wrap helpers shared by the clock counters
package clock_pkg;
    localparam int TIME_W = 6;
    localparam logic [TIME_W-1:0] SEC_MAX = TIME_W'(59);
    localparam logic [TIME_W-1:0] MIN_MAX = TIME_W'(59);
    typedef enum logic {MODE_RUN = 1'b0, MODE_SET = 1'b1} mode_e;
    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v, input logic [TIME_W-1:0] max);
        return (v == max) ? '0 : v + 1'b1;
    endfunction
    function automatic logic [TIME_W-1:0] wrap_dec(input logic [TIME_W-1:0] v, input logic [TIME_W-1:0] max);
        return (v == '0) ? max : v - 1'b1;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizer + debouncer for an active-low button, one strobe per press
// MINUTE_CNT_AUTOREPEAT_EN adds hold-to-repeat strobes
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef MINUTE_CNT_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_CYCLES = 12500000
`endif
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_strobe
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0] r_sync;
    logic r_stable;
    logic [DB_W-1:0] r_db_cnt;
    logic r_strobe;
    logic w_accept;
    logic w_repeat;
    assign w_accept = (r_sync[1] != r_stable) && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign o_strobe = r_strobe;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_db_cnt <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_btn_n};
            r_stable <= w_accept ? r_sync[1] : r_stable;
            r_db_cnt <= (r_sync[1] == r_stable || w_accept) ? '0 : r_db_cnt + 1'b1;
            r_strobe <= (w_accept && !r_sync[1]) || w_repeat;
        end
    end
`ifdef MINUTE_CNT_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int RP_W = $clog2(RP_MAX + 1);
    logic [RP_W-1:0] r_rep_cnt;
    logic r_rep_phase;
    logic w_rep_due;
    // phase 0 waits out the initial hold delay, phase 1 runs the repeat period
    assign w_rep_due = r_rep_cnt == (r_rep_phase ? RP_W'(REPEAT_CYCLES - 1) : RP_W'(REPEAT_DELAY - 1));
    assign w_repeat = !r_stable && !r_sync[1] && w_rep_due;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || r_stable) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else begin
            r_rep_cnt   <= w_rep_due ? '0 : r_rep_cnt + 1'b1;
            r_rep_phase <= r_rep_phase || w_rep_due;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif
endmodule

// File: rtl/minute_counter.sv
// minute_counter: run-mode seconds/minutes counter with carry, set-mode minute adjust by buttons
// Optional auto-repeat on held buttons: define MINUTE_CNT_AUTOREPEAT_EN
module minute_counter
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef MINUTE_CNT_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_CYCLES = 12500000
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sec_tick,
    input  logic              i_mode,
    input  logic              i_add,
    input  logic              i_deduct,
    output logic [TIME_W-1:0] o_second,
    output logic [TIME_W-1:0] o_minute,
    output logic              o_carry
);
    logic r_mode_meta;
    mode_e r_mode;
    mode_e w_mode_nxt;
    logic [TIME_W-1:0] r_second, r_minute;
    logic [TIME_W-1:0] w_second_nxt, w_minute_nxt;
    logic r_carry;
    logic w_carry_nxt;
    logic w_inc, w_dec;
    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef MINUTE_CNT_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_add (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_btn_n(i_add),
        .o_strobe(w_inc)
    );
    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef MINUTE_CNT_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_deduct (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_btn_n(i_deduct),
        .o_strobe(w_dec)
    );
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode_meta <= 1'b0;
            r_mode      <= MODE_RUN;
            r_second    <= '0;
            r_minute    <= '0;
            r_carry     <= 1'b0;
        end else begin
            r_mode_meta <= i_mode;
            r_mode      <= w_mode_nxt;
            r_second    <= w_second_nxt;
            r_minute    <= w_minute_nxt;
            r_carry     <= w_carry_nxt;
        end
    end
    // set mode freezes seconds at 0; simultaneous inc/dec cancel out
    always_comb begin
        w_mode_nxt   = mode_e'(r_mode_meta);
        w_second_nxt = r_second;
        w_minute_nxt = r_minute;
        w_carry_nxt  = 1'b0;
        if (r_mode == MODE_SET) begin
            w_second_nxt = '0;
            w_minute_nxt = (w_inc && !w_dec) ? wrap_inc(r_minute, MIN_MAX) :
                           (w_dec && !w_inc) ? wrap_dec(r_minute, MIN_MAX) : r_minute;
        end else if (i_sec_tick) begin
            w_second_nxt = wrap_inc(r_second, SEC_MAX);
            w_minute_nxt = (r_second == SEC_MAX) ? wrap_inc(r_minute, MIN_MAX) : r_minute;
            w_carry_nxt  = (r_second == SEC_MAX) && (r_minute == MIN_MAX);
        end
    end
    assign o_second = r_second;
    assign o_minute = r_minute;
    assign o_carry  = r_carry;
endmodule

// File: tb/tb_minute_counter.sv
// tb_minute_counter: scoreboard bench for minute_counter (honours MINUTE_CNT_AUTOREPEAT_EN)
module tb_minute_counter;
`ifdef MINUTE_CNT_AUTOREPEAT_EN
    localparam int HOLD_INC = 6;
`else
    localparam int HOLD_INC = 1;
`endif
    logic clk = 1'b0;
    logic rst, sec_tick, mode, add, deduct;
    logic [5:0] second, minute;
    logic carry;
    typedef struct {
        int due;
        string name;
        int sec;
        int min;
        int car;
        int ncar;
    } exp_t;
    exp_t q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n_carry = 0;

    minute_counter #(
        .DEBOUNCE_CYCLES(4)
`ifdef MINUTE_CNT_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY(20),
        .REPEAT_CYCLES(8)
`endif
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_sec_tick(sec_tick),
        .i_mode(mode),
        .i_add(add),
        .i_deduct(deduct),
        .o_second(second),
        .o_minute(minute),
        .o_carry(carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (carry) n_carry++;
        while (q.size() != 0 && q[0].due <= cyc) begin : chk
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (second !== 6'(e.sec) || minute !== 6'(e.min) || carry !== 1'(e.car) || n_carry != e.ncar) begin
                n_bad++;
                $display("FAIL %s: got sec=%0d min=%0d carry=%b carries=%0d, want sec=%0d min=%0d carry=%0d carries=%0d",
                         e.name, second, minute, carry, n_carry, e.sec, e.min, e.car, e.ncar);
            end
        end
    end

    task automatic want(input string name, input int s, input int m, input int c, input int nc);
        exp_t e;
        e.due = cyc; e.name = name; e.sec = s; e.min = m; e.car = c; e.ncar = nc;
        q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        cycles(1);
        sec_tick = 1'b0;
    endtask

    task automatic press(input bit a, input bit d, input int n);
        if (a) add = 1'b0;
        if (d) deduct = 1'b0;
        cycles(n);
        add = 1'b1;
        deduct = 1'b1;
        cycles(12);
    endtask

    task automatic set_mode(input bit v);
        mode = v;
        cycles(4);
    endtask

    initial begin
        rst = 1'b1; sec_tick = 1'b0; mode = 1'b0; add = 1'b1; deduct = 1'b1;
        cycles(3);
        rst = 1'b0;
        want("reset", 0, 0, 0, 0);
        cycles(1);
        for (int i = 0; i < 60; i++) begin
            tick();
            want("run_tick", (i + 1) % 60, (i == 59) ? 1 : 0, 0, 0);
        end
        set_mode(1'b1);
        want("enter_set", 0, 1, 0, 0);
        press(1'b0, 1'b1, 8);
        want("dec_1_to_0", 0, 0, 0, 0);
        press(1'b0, 1'b1, 8);
        want("dec_wrap", 0, 59, 0, 0);
        press(1'b1, 1'b0, 8);
        want("inc_wrap", 0, 0, 0, 0);
        press(1'b0, 1'b1, 8);
        set_mode(1'b0);
        for (int i = 0; i < 59; i++) tick();
        want("preload", 59, 59, 0, 0);
        tick();
        want("minute_wrap", 0, 0, 1, 1);
        cycles(1);
        want("carry_drop", 0, 0, 0, 1);
        set_mode(1'b1);
        for (int i = 0; i < 3; i++) begin
            add = 1'b0;
            cycles(1);
            add = 1'b1;
            cycles(1);
        end
        add = 1'b0;
        cycles(10);
        add = 1'b1;
        cycles(12);
        want("bounce_press", 0, 1, 0, 1);
        add = 1'b0;
        cycles(3);
        add = 1'b1;
        cycles(12);
        want("glitch", 0, 1, 0, 1);
        press(1'b1, 1'b1, 8);
        want("inc_dec_same", 0, 1, 0, 1);
        tick();
        want("tick_in_set", 0, 1, 0, 1);
        add = 1'b0;
        cycles(60);
        add = 1'b1;
        cycles(20);
        want("hold", 0, 1 + HOLD_INC, 0, 1);
        add = 1'b0;
        cycles(10);
        want("pre_reset", 0, 2 + HOLD_INC, 0, 1);
        cycles(1);
        rst = 1'b1;
        mode = 1'b0;
        add = 1'b1;
        want("async_reset", 0, 0, 0, 1);
        cycles(2);
        rst = 1'b0;
        cycles(4);
        tick();
        want("post_reset_tick", 1, 0, 0, 1);
        cycles(5);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending checks, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end
endmodule
